// File: rtl/button_event_pkg.sv
// Shared types for the button gesture decoder: FSM states and event codes.
package button_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_WAIT_SECOND    = 3'd2,
        ST_SECOND_PRESSED = 3'd3,
        ST_LONG_HELD      = 3'd4
    } state_e;

    typedef logic [1:0] evt_code_t;

    localparam evt_code_t EVT_NONE   = 2'b00;
    localparam evt_code_t EVT_SHORT  = 2'b01;
    localparam evt_code_t EVT_LONG   = 2'b10;
    localparam evt_code_t EVT_DOUBLE = 2'b11;

endpackage

// File: rtl/event_slot.sv
// One-entry output holding register. A new event that finds the slot full
// and not being drained is dropped and reported on overflow_o.
module event_slot
    import button_event_pkg::*;
(
    input  logic      clk,
    input  logic      n_reset,
    input  logic      load_valid_i,
    input  evt_code_t load_code_i,
    input  logic      ready_i,
    output logic      valid_o,
    output evt_code_t code_o,
    output logic      overflow_o
);

    logic      valid_q, valid_d;
    evt_code_t code_q, code_d;
    logic      overflow_q, overflow_d;
    logic      accept;

    assign accept = valid_q & ready_i;

    always_comb begin
        valid_d    = valid_q;
        code_d     = code_q;
        overflow_d = 1'b0;
        if (load_valid_i) begin
            // Slot is free either because it is empty or is handing off this cycle.
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                code_d  = load_code_i;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            code_d  = EVT_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            valid_q    <= 1'b0;
            code_q     <= EVT_NONE;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid_o    = valid_q;
    assign code_o     = code_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into SHORT / LONG / DOUBLE events.
//
// state             | meaning
// ST_IDLE           | button released, no gesture in progress
// ST_PRESSED        | first press, counting hold time toward LONG
// ST_WAIT_SECOND    | released after short press, counting gap toward SHORT
// ST_SECOND_PRESSED | second press of a DOUBLE, waiting for release
// ST_LONG_HELD      | LONG already reported, waiting for release
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES = 1_200_000,
    parameter int GAP_CYCLES  = 300_000,
    parameter int CNT_W       = 21
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       db_in,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [1:0] event_code,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             db_prev_q;
    logic             rise, fall;
    logic             gen_valid;
    evt_code_t        gen_code;

    assign rise    = db_in & ~db_prev_q;
    assign fall    = ~db_in & db_prev_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gen_valid = 1'b0;
        gen_code  = EVT_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d = ST_WAIT_SECOND;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LONG_TC && db_in) begin
                        gen_valid = 1'b1;
                        gen_code  = EVT_LONG;
                        state_d   = ST_LONG_HELD;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (fall) state_d = ST_IDLE;
            end
            ST_WAIT_SECOND: begin
                // A second press on the gap's last cycle still makes a DOUBLE.
                if (rise) begin
                    state_d = ST_SECOND_PRESSED;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q == GAP_TC) begin
                        gen_valid = 1'b1;
                        gen_code  = EVT_SHORT;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_SECOND_PRESSED: begin
                if (fall) begin
                    gen_valid = 1'b1;
                    gen_code  = EVT_DOUBLE;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            db_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            db_prev_q <= db_in;
        end
    end

    event_slot u_slot (
        .clk          (clk),
        .n_reset      (n_reset),
        .load_valid_i (gen_valid),
        .load_code_i  (gen_code),
        .ready_i      (event_ready),
        .valid_o      (event_valid),
        .code_o       (event_code),
        .overflow_o   (overflow)
    );

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with short timing parameters.
module tb_button_event_decoder;
    import button_event_pkg::*;

    localparam int LONG = 20;
    localparam int GAP  = 8;
    localparam int CW   = 5;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       db_in = 1'b0;
    logic       event_ready = 1'b1;
    logic       event_valid;
    logic [1:0] event_code;
    logic       overflow;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ovf_cnt = 0;
    int   ovf_cyc = -1;

    button_event_decoder #(
        .LONG_CYCLES (LONG),
        .GAP_CYCLES  (GAP),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .db_in       (db_in),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_code  (event_code),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        db_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input logic [1:0] code, input int at_cyc);
        exp_t e;
        e.code = code;
        e.cyc  = at_cyc;
        sb_q.push_back(e);
    endtask

    // Monitor: every freshly presented event is matched against the scoreboard.
    initial begin
        logic       last_valid = 1'b0;
        logic       last_hs = 1'b0;
        logic [1:0] last_code = 2'b00;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!event_valid) begin
                chk("code_idle", event_code, EVT_NONE);
            end else if (!last_valid || last_hs) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", event_code, EVT_NONE);
                end else begin
                    e = sb_q.pop_front();
                    chk("evt_code", event_code, e.code);
                    chk("evt_cyc", cyc, e.cyc);
                end
            end else begin
                chk("evt_hold", event_code, last_code);
            end
            if (overflow) begin
                ovf_cnt++;
                ovf_cyc = cyc;
            end
            last_valid = event_valid;
            last_hs    = event_valid & event_ready;
            last_code  = event_code;
            if (cyc > 5000) begin
                $display("FAIL watchdog cyc=%0d limit=5000", cyc);
                $fatal(1);
            end
        end
    end

    initial begin
        int r;
        int f;
        int ovf_base;

        // reset state
        n_reset = 1'b0;
        event_ready = 1'b1;
        hold(0, 3);
        chk("rst_valid", event_valid, 0);
        chk("rst_code", event_code, EVT_NONE);
        chk("rst_ovf", overflow, 0);
        n_reset = 1'b1;
        hold(0, 5);

        // short press: SHORT 7 cycles after the release edge
        hold(1, 5);
        f = cyc + 1;
        sb_push(EVT_SHORT, f + GAP - 1);
        hold(0, 20);

        // long press: LONG on the 20th held cycle, nothing at release
        r = cyc + 1;
        sb_push(EVT_LONG, r + LONG - 1);
        hold(1, 30);
        hold(0, 20);

        // double click
        hold(1, 3);
        hold(0, 4);
        hold(1, 3);
        f = cyc + 1;
        sb_push(EVT_DOUBLE, f);
        hold(0, 20);

        // held one cycle short of LONG -> SHORT
        hold(1, LONG - 1);
        f = cyc + 1;
        sb_push(EVT_SHORT, f + GAP - 1);
        hold(0, 20);

        // held exactly LONG cycles -> LONG
        r = cyc + 1;
        sb_push(EVT_LONG, r + LONG - 1);
        hold(1, LONG);
        hold(0, 20);

        // second press on the last gap cycle -> DOUBLE
        hold(1, 3);
        hold(0, GAP - 1);
        hold(1, 3);
        f = cyc + 1;
        sb_push(EVT_DOUBLE, f);
        hold(0, 20);

        // second press one cycle too late -> two SHORTs
        hold(1, 3);
        f = cyc + 1;
        sb_push(EVT_SHORT, f + GAP - 1);
        hold(0, GAP);
        hold(1, 3);
        f = cyc + 1;
        sb_push(EVT_SHORT, f + GAP - 1);
        hold(0, 20);

        // consumer stalled: SHORT held, LONG dropped with one overflow pulse
        ovf_base = ovf_cnt;
        event_ready = 1'b0;
        hold(1, 3);
        f = cyc + 1;
        sb_push(EVT_SHORT, f + GAP - 1);
        hold(0, 12);
        r = cyc + 1;
        hold(1, 25);
        hold(0, 10);
        chk("ovf_count", ovf_cnt - ovf_base, 1);
        chk("ovf_cyc", ovf_cyc, r + LONG - 1);
        chk("ovf_held_valid", event_valid, 1);
        chk("ovf_held_code", event_code, EVT_SHORT);
        event_ready = 1'b1;
        hold(0, 5);

        // new event in the handshake cycle loads without overflow
        ovf_base = ovf_cnt;
        event_ready = 1'b0;
        hold(1, 3);
        f = cyc + 1;
        sb_push(EVT_SHORT, f + GAP - 1);
        hold(0, 12);
        r = cyc + 1;
        sb_push(EVT_LONG, r + LONG - 1);
        hold(1, LONG - 2);
        @(posedge clk);
        #1;
        event_ready = 1'b1;
        hold(1, 5);
        hold(0, 10);
        chk("hs_no_ovf", ovf_cnt - ovf_base, 0);

        // reset mid-press discards the gesture
        hold(1, 10);
        n_reset = 1'b0;
        hold(1, 20);
        hold(0, 2);
        n_reset = 1'b1;
        hold(0, 30);
        chk("rstp_valid", event_valid, 0);
        chk("rstp_code", event_code, EVT_NONE);
        chk("rstp_ovf", overflow, 0);

        // reset mid-gap discards the pending SHORT
        hold(1, 3);
        hold(0, 3);
        n_reset = 1'b0;
        hold(0, 2);
        n_reset = 1'b1;
        hold(0, 20);
        chk("rstg_valid", event_valid, 0);

        // button already held when reset releases counts as a press
        n_reset = 1'b0;
        hold(1, 2);
        n_reset = 1'b1;
        r = cyc + 1;
        sb_push(EVT_LONG, r + LONG - 1);
        hold(1, 25);
        hold(0, 10);

        chk("sb_drained", sb_q.size(), 0);
        chk("ovf_total", ovf_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
